rv32i_core: RTL and testbench

- Single-cycle RV32I integer core, register-only subset.
- Fetches one instruction per clock from an external, combinationally read instruction memory, then executes it and writes back in the same cycle.
- Sits between the top level and the instruction memory and has no data-memory port.
- Instruction word 0xFFFFFFFF is the halt sentinel.

---
 rtl/rv32i_pkg.sv | 76 +++++++
 rtl/rv32i_regfile.sv | 34 +++
 rtl/rv32i_core.sv | 203 ++++++++++++++++++++
 tb/tb_rv32i_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared constants, ALU operation enum and ALU evaluation helper for the
// single-cycle RV32I core.
package rv32i_pkg;

    // Major opcodes of the supported instruction groups
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for JALR
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Halt sentinel instruction word
    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // Pure 32-bit ALU; shift amounts use b[4:0], arithmetic wraps modulo 2^32
    function automatic logic [31:0] alu_eval(input alu_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << b[4:0];
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a >> b[4:0];
            ALU_SRA:  res = $signed(a) >>> b[4:0];
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            default:  res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: two combinational read ports, one
// synchronous write port, asynchronous clear. x0 is hardwired to zero.
module rv32i_regfile
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    output logic [31:0] rd_data_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_b
);

    logic [31:0] r_regs [32];

    // Storage update: clear on reset, otherwise write rd (never x0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read ports return the pre-write value; x0 forced to zero
    assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : r_regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : r_regs[rd_addr_b];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core (register-only subset). Each rising edge commits
// the instruction presented on i_imemData: writeback plus PC update.
// Unsupported encodings retire as NOP; the all-ones word halts the core
// until reset.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_imemData,
    output logic [31:0] o_imemAddr
);

    logic [31:0] pc;
    logic        halted;

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        is_op;

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc_plus4;

    alu_op_e     alu_op;
    logic        alu_legal;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    logic        branch_legal;
    logic        branch_taken;

    logic        wb_en;
    logic [31:0] wb_data;
    logic [31:0] next_pc;
    logic        is_halt;
    logic        commit;

    assign insn   = i_imemData;
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];
    assign is_op  = (opcode == OPC_OP);

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    assign pc_plus4 = pc + 32'd4;
    assign is_halt  = (insn == HALT_INSN);
    assign commit   = !halted && !is_halt;

    rv32i_regfile u_regfile (
        .clk       (i_clock),
        .rst       (i_reset),
        .wr_en     (commit && wb_en),
        .wr_addr   (rd),
        .wr_data   (wb_data),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_val),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_val)
    );

    // ALU operation select for OP / OP-IMM; flags reserved funct7 patterns.
    // OP-IMM ignores funct7 except on shifts, where it carries the SRA bit.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            F3_ADD_SUB: begin
                if (is_op && funct7 == F7_ALT) alu_op = ALU_SUB;
                else if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_SLL: begin
                alu_op = ALU_SLL;
                if (funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_SLT: begin
                alu_op = ALU_SLT;
                if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_SLTU: begin
                alu_op = ALU_SLTU;
                if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_XOR: begin
                alu_op = ALU_XOR;
                if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_SRL_SRA: begin
                if (funct7 == F7_ALT) alu_op = ALU_SRA;
                else if (funct7 == F7_BASE) alu_op = ALU_SRL;
                else alu_legal = 1'b0;
            end
            F3_OR: begin
                alu_op = ALU_OR;
                if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            F3_AND: begin
                alu_op = ALU_AND;
                if (is_op && funct7 != F7_BASE) alu_legal = 1'b0;
            end
            default: alu_legal = 1'b0;
        endcase
    end

    assign alu_b      = is_op ? rs2_val : imm_i;
    assign alu_result = alu_eval(alu_op, rs1_val, alu_b);

    // Branch condition; funct3 010/011 are reserved and never taken
    always_comb begin
        branch_legal = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = (rs1_val == rs2_val);
            F3_BNE:  branch_taken = (rs1_val != rs2_val);
            F3_BLT:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: branch_taken = (rs1_val < rs2_val);
            F3_BGEU: branch_taken = (rs1_val >= rs2_val);
            default: branch_legal = 1'b0;
        endcase
    end

    // Writeback value and next PC per opcode; anything unrecognised is a NOP
    always_comb begin
        wb_en   = 1'b0;
        wb_data = 32'd0;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OPC_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                    next_pc = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (branch_legal && branch_taken) next_pc = pc + imm_b;
            end
            OPC_OP, OPC_OP_IMM: begin
                if (alu_legal) begin
                    wb_en   = 1'b1;
                    wb_data = alu_result;
                end
            end
            default: ;
        endcase
        // No misalignment trap: targets are simply word-aligned
        next_pc[1:0] = 2'b00;
    end

    // PC register: advances on every committed instruction, held when halted
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc <= RESET_PC;
        end else if (commit) begin
            pc <= next_pc;
        end
    end

    // Halted flag: set by the sentinel word, cleared only by reset
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            halted <= 1'b0;
        end else if (is_halt) begin
            halted <= 1'b1;
        end
    end

    assign o_imemAddr = pc;

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed scenarios followed by random instruction
// streams, all compared against an instruction-level reference model.
module tb_rv32i_core;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_imemData;
    logic [31:0] o_imemAddr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_halt;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_imemData (i_imemData),
        .o_imemAddr (o_imemAddr)
    );

    // Clock
    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("%s x%0d", tag, i), dut.u_regfile.r_regs[i], m_regs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc   = 32'd0;
        m_halt = 1'b0;
    endtask

    function automatic void model_write(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endfunction

    // Instruction-level semantics straight from the ISA rules
    function automatic void model_step(input logic [31:0] w);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] a, b, ii, ib, iu, ij, npc;
        logic [4:0]  sh;
        if (m_halt) return;
        if (w == HALT) begin
            m_halt = 1'b1;
            return;
        end
        opc = w[6:0];
        rd  = w[11:7];
        f3  = w[14:12];
        f7  = w[31:25];
        a   = m_regs[w[19:15]];
        b   = m_regs[w[24:20]];
        ii  = $signed(w) >>> 20;
        iu  = w & 32'hFFFF_F000;
        ib  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        ij  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        npc = m_pc + 32'd4;
        case (opc)
            7'h37: model_write(rd, iu);
            7'h17: model_write(rd, m_pc + iu);
            7'h6F: begin model_write(rd, m_pc + 32'd4); npc = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin
                npc = (a + ii) & 32'hFFFF_FFFE;
                model_write(rd, m_pc + 32'd4);
            end
            7'h63: begin
                case (f3)
                    3'd0: if (a == b) npc = m_pc + ib;
                    3'd1: if (a != b) npc = m_pc + ib;
                    3'd4: if ($signed(a) <  $signed(b)) npc = m_pc + ib;
                    3'd5: if ($signed(a) >= $signed(b)) npc = m_pc + ib;
                    3'd6: if (a <  b) npc = m_pc + ib;
                    3'd7: if (a >= b) npc = m_pc + ib;
                    default: ;
                endcase
            end
            7'h13: begin
                sh = w[24:20];
                case (f3)
                    3'd0: model_write(rd, a + ii);
                    3'd2: model_write(rd, ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0);
                    3'd3: model_write(rd, (a < ii) ? 32'd1 : 32'd0);
                    3'd4: model_write(rd, a ^ ii);
                    3'd6: model_write(rd, a | ii);
                    3'd7: model_write(rd, a & ii);
                    3'd1: if (f7 == 7'h00) model_write(rd, a << sh);
                    3'd5: begin
                        if (f7 == 7'h00) model_write(rd, a >> sh);
                        else if (f7 == 7'h20) model_write(rd, $signed(a) >>> sh);
                    end
                    default: ;
                endcase
            end
            7'h33: begin
                sh = b[4:0];
                case ({f7, f3})
                    {7'h00, 3'd0}: model_write(rd, a + b);
                    {7'h20, 3'd0}: model_write(rd, a - b);
                    {7'h00, 3'd1}: model_write(rd, a << sh);
                    {7'h00, 3'd2}: model_write(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    {7'h00, 3'd3}: model_write(rd, (a < b) ? 32'd1 : 32'd0);
                    {7'h00, 3'd4}: model_write(rd, a ^ b);
                    {7'h00, 3'd5}: model_write(rd, a >> sh);
                    {7'h20, 3'd5}: model_write(rd, $signed(a) >>> sh);
                    {7'h00, 3'd6}: model_write(rd, a | b);
                    {7'h00, 3'd7}: model_write(rd, a & b);
                    default: ;
                endcase
            end
            default: ;
        endcase
        m_pc = npc & 32'hFFFF_FFFC;
    endfunction

    // Driver: present one word, let one edge commit it, compare PC and regs
    task automatic run_insn(input logic [31:0] w);
        i_imemData = w;
        @(posedge i_clock);
        #1;
        model_step(w);
        check_eq("pc", o_imemAddr, m_pc);
        check_regs("reg");
    endtask

    // Driver: assert reset (PC must follow without a clock), release at negedge
    task automatic do_reset();
        i_reset    = 1'b1;
        i_imemData = NOP;
        #1;
        model_reset();
        check_eq("reset pc", o_imemAddr, 32'd0);
        @(negedge i_clock);
        check_regs("reset");
        i_reset = 1'b0;
    endtask

    function automatic logic [6:0] pick_f7();
        int r;
        logic [31:0] v;
        r = $urandom_range(0, 9);
        v = $urandom;
        if (r < 4) return 7'h20;
        if (r == 9) return v[6:0];
        return 7'h00;
    endfunction

    function automatic logic [31:0] gen_insn();
        logic [31:0] r32;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [11:0] imm;
        r32 = $urandom;
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1: begin
                f7 = pick_f7();
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            2, 3: begin
                imm = r32[11:0];
                if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = pick_f7();
                return {imm, rs1, f3, rd, 7'h13};
            end
            4: return {r32[31:12], rd, 7'h37};
            5: return {r32[31:12], rd, 7'h17};
            6: return {r32[31:25], rs2, rs1, f3, r32[11:7], 7'h63};
            7: return {r32[31:12], rd, 7'h6F};
            8: begin
                if ($urandom_range(0, 7) != 0) f3 = 3'd0;
                return {r32[31:20], rs1, f3, rd, 7'h67};
            end
            default: begin
                case ($urandom_range(0, 4))
                    0: opc = 7'h03;
                    1: opc = 7'h23;
                    2: opc = 7'h0F;
                    3: opc = 7'h73;
                    default: opc = 7'($urandom);
                endcase
                return {r32[31:7], opc};
            end
        endcase
    endfunction

    initial begin
        i_reset    = 1'b1;
        i_imemData = NOP;
        model_reset();

        // Reset and sequential fetch
        do_reset();
        for (int i = 0; i < 3; i++) run_insn(NOP);
        check_eq("seq pc", o_imemAddr, 32'h0000_000C);
        i_reset = 1'b1;
        #1;
        check_eq("async reset pc", o_imemAddr, 32'h0000_0000);
        do_reset();

        // ALU arithmetic
        run_insn(32'h0050_0093);
        run_insn(32'hFFD0_0113);
        run_insn(32'h0020_81B3);
        run_insn(32'h4020_8233);
        run_insn(32'h1234_52B7);
        check_eq("addi x1", dut.u_regfile.r_regs[1], 32'd5);
        check_eq("addi x2", dut.u_regfile.r_regs[2], 32'hFFFF_FFFD);
        check_eq("add x3",  dut.u_regfile.r_regs[3], 32'd2);
        check_eq("sub x4",  dut.u_regfile.r_regs[4], 32'd8);
        check_eq("lui x5",  dut.u_regfile.r_regs[5], 32'h1234_5000);

        // Branches, jumps, x0, illegal
        do_reset();
        run_insn(32'h0050_0093);
        for (int i = 0; i < 3; i++) run_insn(NOP);
        check_eq("pc before beq", o_imemAddr, 32'h0000_0010);
        run_insn(32'h0010_8463);
        check_eq("beq taken", o_imemAddr, 32'h0000_0018);
        run_insn(32'h0020_8463);
        check_eq("beq not taken", o_imemAddr, 32'h0000_001C);
        run_insn(NOP);
        run_insn(32'h0100_00EF);
        check_eq("jal link", dut.u_regfile.r_regs[1], 32'h0000_0024);
        check_eq("jal pc", o_imemAddr, 32'h0000_0030);
        run_insn(32'h0000_8067);
        check_eq("jalr pc", o_imemAddr, 32'h0000_0024);
        run_insn(32'h0070_0013);
        check_eq("x0 zero", dut.u_regfile.r_regs[0], 32'd0);
        run_insn(32'h0000_2303);
        check_eq("load nop x6", dut.u_regfile.r_regs[6], 32'd0);
        check_eq("load nop pc", o_imemAddr, 32'h0000_002C);

        // Halt
        for (int i = 0; i < 5; i++) run_insn(NOP);
        check_eq("pc before halt", o_imemAddr, 32'h0000_0040);
        run_insn(HALT);
        for (int i = 0; i < 5; i++) begin
            run_insn((i % 2 == 0) ? 32'h0050_0093 : HALT);
            check_eq("halt pc", o_imemAddr, 32'h0000_0040);
            check_eq("halt x1", dut.u_regfile.r_regs[1], 32'h0000_0024);
        end
        do_reset();
        run_insn(32'h0050_0093);
        check_eq("resume x1", dut.u_regfile.r_regs[1], 32'd5);
        check_eq("resume pc", o_imemAddr, 32'h0000_0004);

        // Random instruction streams with occasional halts and resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                run_insn(HALT);
                for (int k = 0; k < 3; k++) run_insn(gen_insn());
                do_reset();
            end else if (r < 3) begin
                i_reset = 1'b1;
                do_reset();
            end else begin
                run_insn(gen_insn());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
